id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  Instruction-decode stage directly upstream of RegFile. Accepts one 32-bit RV32I
//  instruction per handshake from fetch, drives rs1/rs2 read addresses into RegFile,
//  checks a register scoreboard for RAW/WAW hazards and captures decoded fields plus
//  operands into the ID/EX pipeline register. Writeback reports retirement through wb_*.
// PARAMETERS
//  XLEN  32  datapath width; RegFile operand width and pc width
// PORTS
//  clk          in   1     clock, all state updates on posedge
//  rst_n        in   1     asynchronous active-low reset
//  if_valid     in   1     fetch presents if_instr/if_pc
//  if_ready     out  1     ID accepts fetch word this cycle
//  if_instr     in   32    instruction word
//  if_pc        in   XLEN  pc of if_instr
//  rs1          out  5     RegFile read address 1 (= if_instr[19:15], combinational)
//  rs2          out  5     RegFile read address 2 (= if_instr[24:20], combinational)
//  rs1_out      in   XLEN  RegFile read data 1
//  rs2_out      in   XLEN  RegFile read data 2
//  wb_valid     in   1     writeback retires a write this cycle
//  wb_rd        in   5     destination of retiring write
//  wb_data      in   XLEN  value being written (same value RegFile gets as rd_in)
//  flush        in   1     kill ID/EX contents and fetch word (branch redirect)
//  ex_valid     out  1     ID/EX register holds an instruction
//  ex_ready     in   1     execute consumes ID/EX this cycle
//  ex_opcode    out  7     instr[6:0]
//  ex_funct3    out  3     instr[14:12]
//  ex_funct7b5  out  1     instr[30]
//  ex_rd        out  5     destination register
//  ex_rd_w      out  1     instruction writes rd (forced 0 when rd==0)
//  ex_rs1_val   out  XLEN  operand 1
//  ex_rs2_val   out  XLEN  operand 2
//  ex_imm       out  XLEN  sign-extended immediate (I/S/B/U/J by opcode; 0 for OP)
//  ex_pc        out  XLEN  pc of the instruction
//  ex_illegal   out  1     opcode not in RV32I base set
// BEHAVIOUR
//  - Reset (async, rst_n=0): ex_valid=0, busy[31:0]=0, all ex_* data outputs 0.
//  - rd_w set for LUI,AUIPC,JAL,JALR,LOAD,OP-IMM,OP; clear for STORE,BRANCH,MISC-MEM,SYSTEM.
//  - Uses rs1: all but LUI/AUIPC/JAL; uses rs2: STORE,BRANCH,OP only.
//  - busy[r]: write outstanding past ID/EX. Set on ex_valid&&ex_ready&&ex_rd_w (reg ex_rd);
//    cleared on wb_valid for wb_rd. Same-cycle set and clear of one reg: set wins.
//    busy[0] is constantly 0.
//  - hazard = for each used source s!=0: busy[s] or (ex_valid&&ex_rd_w&&ex_rd==s);
//    plus WAW: decoded rd_w and (busy[rd] or ex_valid&&ex_rd_w&&ex_rd==rd).
//  - if_ready = !hazard && (!ex_valid || ex_ready) && !flush.
//  - Load ID/EX on if_valid&&if_ready: latency 1 cycle fetch-accept -> ex_valid.
//  - ID/EX holds all outputs stable while ex_valid&&!ex_ready.
//  - ex_valid clears when consumed with no new load, or on flush.
//  - flush: ex_valid<=0 next edge, fetch word not accepted; busy bits untouched
//    (flushed ID/EX never set them).
//  - Illegal opcode: accepted, ex_illegal=1, ex_rd_w=0, no scoreboard effect.
// CONFIGURATION
//  ID_WB_BYPASS_EN defined: a source s with wb_valid&&wb_rd==s&&s!=0 is not a hazard
//    from busy[s]; operand taken from wb_data instead of rs*_out (RegFile still
//    returns old value that cycle). ID/EX-register match still stalls.
//  Undefined: no bypass; a busy source stalls until the cycle after wb, then reads
//    RegFile. Costs 1 extra stall cycle per back-to-back dependence.
// TESTING
//  1 reset mid-stream with ex_valid=1 -> ex_valid=0, if_ready=1 once rst_n=1, busy=0.
//  2 addi x1,x0,5 then addi x2,x1,1; hold wb until cycle 4, wb_rd=1 wb_data=5
//    -> 2nd instr stalls (if_ready=0) until wb; operand=5; 1 cycle less with bypass.
//  3 ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* stable, if_ready=0.
//  4 flush while ex_valid=1 and if_valid=1 -> ex_valid=0 next cycle, word not taken.
//  5 addi x0,x0,7 then add x3,x0,x0 -> ex_rd_w=0, no stall, operands 0.
//  6 sw x2,4(x1) -> ex_rd_w=0, ex_imm=4; if_instr=32'hFFFFFFFF -> ex_illegal=1.

Source files
------------

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetch word, checks a register scoreboard for RAW/WAW
// hazards and loads the ID/EX register. Define ID_WB_BYPASS_EN to forward writeback data.
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] rs1_out,
    input  logic [XLEN-1:0] rs2_out,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_w,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [4:0]      rd_dec;
    logic            legal;
    logic            rd_w_raw;
    logic            rd_w_dec;
    logic            use1;
    logic            use2;
    logic [31:0]     imm32;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic            byp1;
    logic            byp2;
    logic            hz1;
    logic            hz2;
    logic            waw;
    logic            hazard;
    logic            load;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign opcode = if_instr[6:0];
    assign rd_dec = if_instr[11:7];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    always_comb begin
        legal    = 1'b1;
        rd_w_raw = 1'b0;
        use1     = 1'b1;
        use2     = 1'b0;
        imm32    = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                rd_w_raw = 1'b1;
                use1     = 1'b0;
                imm32    = {if_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                rd_w_raw = 1'b1;
                use1     = 1'b0;
                imm32    = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                rd_w_raw = 1'b1;
                imm32    = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_OP: begin
                rd_w_raw = 1'b1;
                use2     = 1'b1;
            end
            OPC_STORE: begin
                use2  = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OPC_BRANCH: begin
                use2  = 1'b1;
                imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
            end
            OPC_MISC, OPC_SYSTEM: begin
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            default: begin
                // Illegal words flow through as bubbles with a flag: no sources, no dest.
                legal = 1'b0;
                use1  = 1'b0;
            end
        endcase
    end

    assign rd_w_dec = legal && rd_w_raw && (rd_dec != 5'd0);

`ifdef ID_WB_BYPASS_EN
    assign byp1 = wb_valid && (wb_rd == rs1) && (rs1 != 5'd0);
    assign byp2 = wb_valid && (wb_rd == rs2) && (rs2 != 5'd0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign op1 = byp1 ? wb_data : rs1_out;
    assign op2 = byp2 ? wb_data : rs2_out;

    // A source still sitting in ID/EX has no data anywhere yet, so it always stalls.
    assign hz1 = use1 && (rs1 != 5'd0) &&
                 ((busy[rs1] && !byp1) || (ex_valid && ex_rd_w && ex_rd == rs1));
    assign hz2 = use2 && (rs2 != 5'd0) &&
                 ((busy[rs2] && !byp2) || (ex_valid && ex_rd_w && ex_rd == rs2));
    assign waw = rd_w_dec && (busy[rd_dec] || (ex_valid && ex_rd_w && ex_rd == rd_dec));

    assign hazard   = hz1 || hz2 || waw;
    assign if_ready = !hazard && (!ex_valid || ex_ready) && !flush;
    assign load     = if_valid && if_ready;

    // Set after clear so a same-cycle set of one register wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid)
            busy_nxt[wb_rd] = 1'b0;
        if (ex_valid && ex_ready && ex_rd_w && !flush)
            busy_nxt[ex_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_rd       <= '0;
            ex_rd_w     <= 1'b0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_illegal  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (load) begin
                ex_valid    <= 1'b1;
                ex_opcode   <= opcode;
                ex_funct3   <= if_instr[14:12];
                ex_funct7b5 <= if_instr[30];
                ex_rd       <= rd_dec;
                ex_rd_w     <= rd_w_dec;
                ex_rs1_val  <= op1;
                ex_rs2_val  <= op2;
                ex_imm      <= XLEN'($signed(imm32));
                ex_pc       <= if_pc;
                ex_illegal  <= !legal;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end
endmodule
